// File: rtl/lsu_port.sv
// Load/store port between a core and a 32-bit word memory: aligned sub-word loads
// with sign/zero extension, read-modify-write sub-word stores, and a read-stall timeout.
module lsu_port #(
  parameter int ADDR_W  = 13,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rd_data,
  input  logic              mem_rd_valid,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_data
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_e;

  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              busy_q, done_q, err_q;
  logic [31:0]       rdata_q;
  logic              rd_en_q, wr_en_q;
  logic [ADDR_W-1:0] maddr_q;
  logic [31:0]       wr_data_q;

  logic              we_q, uns_q;
  logic [1:0]        size_q, off_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;

  logic [31:0]       load_d, merge_d;
  logic [ADDR_W-1:0] base_d;

  function automatic logic is_bad(input logic [1:0] sz, input logic [1:0] off);
    return (sz == 2'd3) || (sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0);
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] off, input logic u);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      2'd0:    r = u ? {24'd0, b} : 32'(b);
      2'd1:    r = u ? {16'd0, h} : 32'(h);
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                        input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] r;
    r = w;
    case (sz)
      2'd0:    r[{off, 3'b000} +: 8]     = d[7:0];
      2'd1:    r[{off[1], 4'b0000} +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  assign base_d  = {addr[ADDR_W-1:2], 2'b00};
  assign load_d  = load_ext(mem_rd_data, size_q, off_q, uns_q);
  assign merge_d = merge(mem_rd_data, wdata_q, size_q, off_q);

  // Request capture: plain data registers, loaded only when a request is accepted
  always_ff @(posedge clk) begin
    if (state_q == IDLE && req) begin
      we_q    <= we;
      uns_q   <= uns;
      size_q  <= size;
      off_q   <= addr[1:0];
      base_q  <= base_d;
      wdata_q <= wdata;
    end
  end

  // Control FSM; every output is registered and derived from the transition taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      maddr_q   <= '0;
      wr_data_q <= '0;
    end else begin
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      maddr_q   <= '0;
      wr_data_q <= '0;
      case (state_q)
        IDLE: begin
          if (req) begin
            busy_q <= 1'b1;
            if (is_bad(size, addr[1:0])) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (we && size == 2'd2) begin
              state_q   <= WRITE;
              wr_en_q   <= 1'b1;
              maddr_q   <= base_d;
              wr_data_q <= wdata;
            end else begin
              state_q <= READ;
              rd_en_q <= 1'b1;
              maddr_q <= base_d;
            end
          end
        end
        READ: begin
          state_q <= WAIT;
          cnt_q   <= '0;
        end
        WAIT: begin
          if (mem_rd_valid) begin
            if (we_q) begin
              state_q   <= WRITE;
              wr_en_q   <= 1'b1;
              maddr_q   <= base_q;
              wr_data_q <= merge_d;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b0;
              rdata_q <= load_d;
            end
          end else if (cnt_q == TMO_LAST) begin
            // Memory never answered: finish with an error and leave memory untouched
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        WRITE: begin
          state_q <= DONE;
          done_q  <= 1'b1;
          err_q   <= 1'b0;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_addr    = maddr_q;
  assign mem_wr_data = wr_data_q;

endmodule

// File: tb/tb_lsu_port.sv
// Bench for lsu_port: the memory is emulated cycle by cycle, results are compared
// against a byte-array model of memory and a model of the held rdata value.
module tb_lsu_port;
  localparam int ADDR_W  = 13;
  localparam int TIMEOUT = 8;
  localparam int NBYTES  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req, we, uns;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              busy, done, err;
  logic [31:0]       rdata;
  logic              mem_rd_en, mem_wr_en, mem_rd_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rd_data, mem_wr_data;

  lsu_port #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_rd_valid(mem_rd_valid), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  rb [0:NBYTES-1];
  logic [31:0] tm [0:NBYTES/4-1];
  logic [31:0] m_rdata;
  int          lat, delay;
  int          raddr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int wi);
    return {rb[4*wi+3], rb[4*wi+2], rb[4*wi+1], rb[4*wi]};
  endfunction

  task automatic set_word(input int wi, input logic [31:0] v);
    for (int k = 0; k < 4; k++) rb[4*wi+k] = v[8*k +: 8];
    tm[wi] = v;
  endtask

  function automatic logic [31:0] ref_load(input int a, input int nb, input logic u);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < nb; k++) v = v | (32'(rb[a+k]) << (8*k));
    if (!u && nb == 1 && v[7])  v = v | 32'hFFFFFF00;
    if (!u && nb == 2 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  // One clock of the emulated memory: read data appears delay+1 cycles after mem_rd_en
  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_wr_en) tm[int'(mem_addr) >> 2] = mem_wr_data;
    if (lat == 1) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = tm[raddr];
    end else if (lat == 0 && !busy) begin
      mem_rd_valid = 1'($urandom_range(0, 1));
      mem_rd_data  = $urandom;
    end else begin
      mem_rd_valid = 1'b0;
      mem_rd_data  = $urandom;
    end
    if (lat > 0) lat--;
    if (mem_rd_en) begin
      lat   = delay + 1;
      raddr = int'(mem_addr) >> 2;
    end
  endtask

  task automatic access(input logic w, input logic [1:0] sz, input logic u, input int a,
                        input logic [31:0] wd, input int d);
    int nb, wi, e_lat, e_rd, e_wr, nrd, nwr, cyc;
    logic bad, tmo, e_err, seen;
    logic [31:0] e_word;
    nb  = 1 << sz;
    bad = (sz == 2'd3) || ((a % nb) != 0);
    tmo = (d >= TIMEOUT);
    wi  = a >> 2;
    if (bad) begin
      e_err = 1; e_lat = 1; e_rd = 0; e_wr = 0;
    end else if (!w) begin
      e_rd = 1; e_wr = 0;
      if (tmo) begin e_err = 1; e_lat = 2 + TIMEOUT; end
      else begin e_err = 0; e_lat = 3 + d; m_rdata = ref_load(a, nb, u); end
    end else if (nb == 4) begin
      e_err = 0; e_lat = 2; e_rd = 0; e_wr = 1;
      for (int k = 0; k < 4; k++) rb[a+k] = wd[8*k +: 8];
    end else begin
      e_rd = 1;
      if (tmo) begin e_err = 1; e_lat = 2 + TIMEOUT; e_wr = 0; end
      else begin
        e_err = 0; e_lat = 4 + d; e_wr = 1;
        for (int k = 0; k < nb; k++) rb[a+k] = wd[8*k +: 8];
      end
    end
    e_word = ref_word(wi);

    delay = d;
    req = 1'b1; we = w; size = sz; uns = u; addr = ADDR_W'(a); wdata = wd;
    tick();
    req = 1'b0; we = 1'($urandom); size = 2'($urandom); uns = 1'($urandom);
    addr = ADDR_W'($urandom); wdata = $urandom;
    cyc = 1; nrd = 0; nwr = 0; seen = 0;
    while (1) begin
      chk("strobe_excl", 32'(mem_rd_en & mem_wr_en), 32'd0);
      if (mem_rd_en) begin
        nrd++;
        chk("rd_addr", 32'(mem_addr), 32'(a & ~3));
      end
      if (mem_wr_en) begin
        nwr++;
        chk("wr_addr", 32'(mem_addr), 32'(a & ~3));
        chk("wr_data", mem_wr_data, e_word);
      end else begin
        chk("wr_data_idle", mem_wr_data, 32'd0);
      end
      if (!mem_rd_en && !mem_wr_en) chk("addr_idle", 32'(mem_addr), 32'd0);
      if (done) begin seen = 1; break; end
      if (cyc >= 40) break;
      chk("busy_op", 32'(busy), 32'd1);
      tick();
      cyc++;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(cyc), 32'(e_lat));
    chk("err", 32'(err), 32'(e_err));
    chk("busy_done", 32'(busy), 32'd1);
    chk("rdata", rdata, m_rdata);
    chk("nrd", 32'(nrd), 32'(e_rd));
    chk("nwr", 32'(nwr), 32'(e_wr));
    tick();
    chk("busy_after", 32'(busy), 32'd0);
    chk("done_after", 32'(done), 32'd0);
    chk("err_held", 32'(err), 32'(e_err));
    chk("mem_word", tm[wi], ref_word(wi));
    while (lat != 0) tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
    chk({tag, "_wr_en"}, 32'(mem_wr_en), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, mem_wr_data, 32'd0);
  endtask

  initial begin
    int w, a, d;
    logic [1:0] sz;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'd0; uns = 1'b0; addr = '0; wdata = '0;
    mem_rd_valid = 1'b0; mem_rd_data = '0; lat = 0; delay = 0; raddr = 0; m_rdata = '0;
    for (int i = 0; i < NBYTES / 4; i++) set_word(i, $urandom);

    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_zero("post_rst");

    set_word(32'h10 >> 2, 32'h8899AABB);
    access(1'b0, 2'd0, 1'b0, 32'h013, 32'h0, 0);
    chk("ld_byte_const", rdata, 32'hFFFFFF88);
    access(1'b0, 2'd1, 1'b1, 32'h012, 32'h0, 0);
    chk("ld_half_const", rdata, 32'h00008899);
    access(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 0);
    chk("ld_word_const", rdata, 32'h8899AABB);
    access(1'b1, 2'd0, 1'b0, 32'h011, 32'h0000005A, 0);
    chk("st_byte_const", tm[4], 32'h88995ABB);
    chk("st_keeps_rdata", rdata, 32'h8899AABB);
    access(1'b1, 2'd2, 1'b0, 32'h006, 32'h12345678, 0);
    access(1'b0, 2'd3, 1'b0, 32'h010, 32'h0, 0);
    access(1'b1, 2'd1, 1'b0, 32'h013, 32'hCAFE, 2);
    access(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 20);
    chk("tmo_rdata_const", rdata, 32'h8899AABB);
    access(1'b0, 2'd1, 1'b0, 32'h010, 32'h0, 3);
    access(1'b1, 2'd1, 1'b0, 32'h022, 32'h0000BEEF, 20);

    // Reset asserted while a byte store waits for read data
    delay = 20;
    req = 1'b1; we = 1'b1; size = 2'd0; uns = 1'b0; addr = ADDR_W'(32'h021); wdata = 32'h77;
    tick();
    req = 1'b0;
    tick();
    tick();
    chk("rst_wait_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    m_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("rel_done", 32'(done), 32'd0);
      chk("rel_wr_en", 32'(mem_wr_en), 32'd0);
      chk("rel_rd_en", 32'(mem_rd_en), 32'd0);
    end
    chk("rst_mem_word", tm[32'h20 >> 2], ref_word(32'h20 >> 2));

    for (int i = 0; i < 120; i++) begin
      w  = $urandom_range(0, 1);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 63) : $urandom_range(0, NBYTES - 1);
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((1 << sz) - 1);
      d  = ($urandom_range(0, 11) == 0) ? 20 : $urandom_range(0, 3);
      access(1'(w), sz, 1'($urandom), a, $urandom, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
